// File: rtl/spk_pwm_decoder.sv
// Recovers 5-bit samples from the SPK pulse-width stream by measuring pulse high time.
// Define SPK_DECODE_TIMEOUT_EN to build silent-frame emission and stuck-high detection.
module spk_pwm_decoder #(
  parameter int FRAME_CYCLES = 6252,
  parameter int GUARD        = 64,
  parameter int MAX_WIDTH    = 27
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       SPK,
  output logic [4:0] sample,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       frame_tick,
  output logic       overrun,
  output logic       pw_err,
  input  logic       clear_flags
);

  localparam logic [4:0] MAX_W = 5'(MAX_WIDTH);
  localparam logic [4:0] SAT_W = 5'd31;

  // Saturated widths must always read as over-width, and a frame must fit a legal pulse.
  if (MAX_WIDTH >= 31 || FRAME_CYCLES + GUARD <= MAX_WIDTH + 2) begin : g_cfg_check
    $error("spk_pwm_decoder: inconsistent FRAME_CYCLES/GUARD/MAX_WIDTH");
  end

`ifdef SPK_DECODE_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, HIGH, STUCK} state_e;
  localparam int TO_W = $clog2(FRAME_CYCLES + GUARD + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRAME_CYCLES + GUARD - 1);
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic            tmo_hit;
`else
  typedef enum logic {IDLE, HIGH} state_e;
`endif

  state_e     state_q, state_d;
  logic       s1_q, s2_q;
  logic [4:0] width_q, width_d;
  logic [4:0] sample_q, sample_d;
  logic       valid_q, valid_d;
  logic       tick_q, tick_d;
  logic       ovr_q, ovr_d;
  logic       err_q, err_d;
  logic       emit, err_set, ovr_set, xfer;
  logic [4:0] emit_val;

`ifdef SPK_DECODE_TIMEOUT_EN
  assign tmo_hit = (tmo_q == TO_LAST);
`endif

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    emit     = 1'b0;
    emit_val = '0;
    err_set  = 1'b0;
`ifdef SPK_DECODE_TIMEOUT_EN
    tmo_d    = tmo_q + 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = HIGH;
          width_d = 5'd1;
`ifdef SPK_DECODE_TIMEOUT_EN
          tmo_d   = '0;
        end else if (tmo_hit) begin
          emit    = 1'b1;
`endif
        end
      end
      HIGH: begin
        if (s2_q) begin
          if (width_q != SAT_W) width_d = width_q + 5'd1;
`ifdef SPK_DECODE_TIMEOUT_EN
          if (tmo_hit) begin
            emit    = 1'b1;
            err_set = 1'b1;
            state_d = STUCK;
          end
`endif
        end else begin
          emit    = 1'b1;
          state_d = IDLE;
          if (width_q <= MAX_W) emit_val = width_q;
          else                  err_set  = 1'b1;
        end
      end
`ifdef SPK_DECODE_TIMEOUT_EN
      // Held high past the frame: wait for the line to drop, still reporting silence.
      STUCK: begin
        if (!s2_q)   state_d = IDLE;
        if (tmo_hit) emit    = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef SPK_DECODE_TIMEOUT_EN
    if (emit) tmo_d = '0;
`endif
  end

  always_comb begin
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_set  = 1'b0;
    xfer     = valid_q & sample_ready;
    tick_d   = emit;
    if (emit) begin
      if (!valid_q || xfer) begin
        sample_d = emit_val;
        valid_d  = 1'b1;
      end else begin
        ovr_set  = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    // A set in the same cycle as a clear wins.
    ovr_d = ovr_set ? 1'b1 : (clear_flags ? 1'b0 : ovr_q);
    err_d = err_set ? 1'b1 : (clear_flags ? 1'b0 : err_q);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= IDLE;
      width_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      tick_q   <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= SPK;
      s2_q     <= s1_q;
      state_q  <= state_d;
      width_q  <= width_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      tick_q   <= tick_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
    end
  end

`ifdef SPK_DECODE_TIMEOUT_EN
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`endif

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_tick   = tick_q;
  assign overrun      = ovr_q;
  assign pw_err       = err_q;

endmodule

// File: tb/tb_spk_pwm_decoder.sv
// Randomized bench for spk_pwm_decoder against a pulse-run reference model.
// Follows SPK_DECODE_TIMEOUT_EN the same way the design does.
module tb_spk_pwm_decoder;

  localparam int FRAME = 6252;
  localparam int GUARD = 64;
  localparam int MAXW  = 27;
  localparam int LIM   = FRAME + GUARD;
`ifdef SPK_DECODE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       SPK = 1'b0;
  logic       sample_ready = 1'b0;
  logic       clear_flags = 1'b0;
  logic [4:0] sample;
  logic       sample_valid, frame_tick, overrun, pw_err;

  spk_pwm_decoder #(.FRAME_CYCLES(FRAME), .GUARD(GUARD), .MAX_WIDTH(MAXW)) dut (
    .Clk(Clk), .reset_n(reset_n), .SPK(SPK), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .frame_tick(frame_tick), .overrun(overrun), .pw_err(pw_err),
    .clear_flags(clear_flags)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: input history, current high-run length and frames since last event.
  logic       m_h1, m_h2;
  int         m_len, m_quiet;
  bit         m_stuck;
  logic [4:0] m_sample;
  logic       m_valid, m_tick, m_ovr, m_err;
  int         dut_ticks;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h1 = 0; m_h2 = 0; m_len = 0; m_quiet = 0; m_stuck = 0;
    m_sample = '0; m_valid = 0; m_tick = 0; m_ovr = 0; m_err = 0;
  endtask

  task automatic model_step(input logic spk_v, input logic rdy_v, input logic clr_v);
    logic d;
    bit   hit, emit, err, rise, drop;
    int   val;
    d = m_h2;               // decoder sees the input two edges late
    m_h2 = m_h1;
    m_h1 = spk_v;
    hit = TO_EN && (m_quiet == LIM - 1);
    emit = 0; err = 0; rise = 0; drop = 0; val = 0;
    if (m_stuck) begin
      if (!d) m_stuck = 0;
      if (hit) emit = 1;
    end else if (m_len > 0) begin
      if (d) begin
        m_len++;
        if (hit) begin emit = 1; err = 1; m_stuck = 1; m_len = 0; end
      end else begin
        emit = 1;
        if (m_len <= MAXW) val = m_len; else err = 1;
        m_len = 0;
      end
    end else if (d) begin
      m_len = 1; rise = 1;
    end else if (hit) begin
      emit = 1;
    end
    m_quiet = (emit || rise) ? 0 : m_quiet + 1;
    if (emit) begin
      if (!m_valid || rdy_v) begin m_sample = 5'(val); m_valid = 1; end
      else drop = 1;
    end else if (m_valid && rdy_v) begin
      m_valid = 0;
    end
    m_tick = emit;
    if (drop) m_ovr = 1; else if (clr_v) m_ovr = 0;
    if (err)  m_err = 1; else if (clr_v) m_err = 0;
  endtask

  // Called at a negedge: drive inputs for the next posedge, then check after it.
  task automatic cyc(input logic spk_v, input logic rdy_v, input logic clr_v);
    SPK = spk_v; sample_ready = rdy_v; clear_flags = clr_v;
    model_step(spk_v, rdy_v, clr_v);
    @(negedge Clk);
    if (frame_tick) dut_ticks++;
    chk("out", {23'd0, sample, sample_valid, frame_tick, overrun, pw_err},
        {23'd0, m_sample, m_valid, m_tick, m_ovr, m_err});
  endtask

  task automatic pulse(input int n, input int gap, input logic rdy);
    for (int i = 0; i < n; i++)   cyc(1'b1, rdy, 1'b0);
    for (int i = 0; i < gap; i++) cyc(1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset(input logic spk_keep);
    reset_n = 1'b0; SPK = spk_keep; sample_ready = 1'b0; clear_flags = 1'b0;
    #1;
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_err", 32'(pw_err), 32'd0);
    model_reset();
    @(negedge Clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int t1, t2, base;
    int widths [6];
    widths = '{1, 27, 28, 31, 32, 45};
    dut_ticks = 0;
    model_reset();
    @(negedge Clk);
    do_reset(1'b0);

    // Silent line from reset release.
    t1 = 0; t2 = 0;
    for (int i = 1; i <= (TO_EN ? 12700 : 7000); i++) begin
      base = dut_ticks;
      cyc(1'b0, 1'b1, 1'b0);
      if (dut_ticks != base) begin
        if (t1 == 0) t1 = i; else if (t2 == 0) t2 = i;
      end
    end
`ifdef SPK_DECODE_TIMEOUT_EN
    chk("silent_first", 32'(t1), 32'd6316);
    chk("silent_second", 32'(t2), 32'd12632);
`else
    chk("no_silent_tick", 32'(t1), 32'd0);
`endif
    chk("silent_pw_err", 32'(pw_err), 32'd0);

    // Legal 12-cycle pulse.
    base = dut_ticks;
    pulse(12, 6, 1'b1);
    chk("legal12_sample", 32'(sample), 32'd12);
    chk("legal12_ticks", 32'(dut_ticks - base), 32'd1);

    // Boundary widths around the legal limit and the counter saturation.
    foreach (widths[k]) begin
      pulse(widths[k], 4, 1'b1);
      chk("width_sample", 32'(sample), (widths[k] <= MAXW) ? 32'(widths[k]) : 32'd0);
      chk("width_err", 32'(pw_err), (widths[k] <= MAXW) ? 32'd0 : 32'd1);
      cyc(1'b0, 1'b1, 1'b1);
    end

    // Over-width then clear.
    pulse(30, 5, 1'b1);
    chk("ovw_err", 32'(pw_err), 32'd1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("ovw_clear", 32'(pw_err), 32'd0);

    // Overrun with a stalled consumer.
    pulse(5, 8, 1'b0);
    pulse(9, 8, 1'b0);
    chk("ovr_keep", 32'(sample), 32'd5);
    chk("ovr_flag", 32'(overrun), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("ovr_drained", 32'(sample_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b1);

    // Randomized pulses, consumer stalls and flag clears.
    for (int p = 0; p < 250; p++) begin
      int n, gap;
      n   = $urandom_range(1, 40);
      gap = $urandom_range(1, 12);
      for (int i = 0; i < n + gap; i++)
        cyc(i < n, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    // Stuck-high line: exactly one emission, an error either way.
    pulse(3, 4, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    base = dut_ticks;
    pulse(7000, 20, 1'b1);
    chk("stuck_ticks", 32'(dut_ticks - base), 32'd1);
    chk("stuck_err", 32'(pw_err), 32'd1);
    chk("stuck_sample", 32'(sample), 32'd0);

    // Reset in the middle of a pulse with a sample pending.
    pulse(4, 5, 1'b0);
    chk("pre_rst_valid", 32'(sample_valid), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);
    do_reset(1'b1);
    pulse(4, 5, 1'b1);
    pulse(7, 5, 1'b1);
    chk("post_rst_w7", 32'(sample), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
